// File: rtl/b_bop_pkg.sv
// Shared definitions for the iterative ternary bitwise-LUT unit:
// FSM state encoding and common truth-table constants.
package b_bop_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LUT_XOR3 = 8'h96;
  localparam logic [7:0] LUT_MAJ  = 8'hE8;
  localparam logic [7:0] LUT_RD   = 8'hF0;
  localparam logic [7:0] LUT_RS1  = 8'hCC;
  localparam logic [7:0] LUT_RS2  = 8'hAA;

endpackage

// File: rtl/b_bop_slice.sv
// Combinational W-bit ternary LUT: result[i] = lut[{rd[i],rs1[i],rs2[i]}].
module b_bop_slice #(
  parameter int W = 8
) (
  input  logic [7:0]   lut,
  input  logic [W-1:0] rd,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic [W-1:0] result
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign result[i] = lut[{rd[i], rs1[i], rs2[i]}];
  end

endmodule

// File: rtl/b_bop_iter.sv
// Iterative ternary bitwise-LUT unit: evaluates CHUNK result bits per cycle
// behind valid/ready request and response handshakes, with flush.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready=1
// S_BUSY | writing one CHUNK-wide slice of result per cycle
// S_DONE | result complete and held, rsp_valid=1 until rsp_ready
module b_bop_iter
  import b_bop_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] rd,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [7:0]      lut,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (XLEN % CHUNK != 0) begin : g_bad_chunk
    $error("b_bop_iter: XLEN must be a multiple of CHUNK");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] op_rd, op_rs1, op_rs2;
  logic [7:0]      op_lut;
  logic [CHUNK-1:0] sl_rd, sl_rs1, sl_rs2, sl_out;
  logic            last;
  int              base;

  assign base   = int'(cnt) * CHUNK;
  assign last   = (cnt == CW'(NCHUNK - 1));
  assign sl_rd  = op_rd[base +: CHUNK];
  assign sl_rs1 = op_rs1[base +: CHUNK];
  assign sl_rs2 = op_rs2[base +: CHUNK];

  b_bop_slice #(.W(CHUNK)) u_slice (
    .lut    (op_lut),
    .rd     (sl_rd),
    .rs1    (sl_rs1),
    .rs2    (sl_rs2),
    .result (sl_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_BUSY;
      S_BUSY:  if (last)      state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);

  // flush clears everything reset does, so both land in the same state
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_rd  <= '0;
      op_rs1 <= '0;
      op_rs2 <= '0;
      op_lut <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_rd  <= rd;
            op_rs1 <= rs1;
            op_rs2 <= rs2;
            op_lut <= lut;
            cnt    <= '0;
          end
        end
        S_BUSY: begin
          result[base +: CHUNK] <= sl_out;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_b_bop_iter.sv
// Randomised self-checking bench for b_bop_iter against a bit-loop LUT model,
// covering the default 8-bit chunk build and a single-chunk (CHUNK=XLEN) build.
module tb_b_bop_iter;
  import b_bop_pkg::*;

  localparam int XLEN   = 32;
  localparam int NCHUNK = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset, flush, req_valid, rsp_ready;
  logic [XLEN-1:0] rd, rs1, rs2;
  logic [7:0]      lut;
  logic            req_ready, rsp_valid;
  logic [XLEN-1:0] result;

  logic            flush_w, req_valid_w, rsp_ready_w;
  logic [XLEN-1:0] rd_w, rs1_w, rs2_w;
  logic [7:0]      lut_w;
  logic            req_ready_w, rsp_valid_w;
  logic [XLEN-1:0] result_w;

  int n_vec = 0;
  int n_err = 0;

  b_bop_iter #(.XLEN(XLEN), .CHUNK(8)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .rd(rd), .rs1(rs1), .rs2(rs2), .lut(lut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .result(result)
  );

  b_bop_iter #(.XLEN(XLEN), .CHUNK(XLEN)) dut_w (
    .clock(clock), .reset(reset), .flush(flush_w),
    .req_valid(req_valid_w), .req_ready(req_ready_w),
    .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .lut(lut_w),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w), .result(result_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_bop(input logic [7:0] l, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
    logic [XLEN-1:0] r;
    int idx;
    for (int i = 0; i < XLEN; i++) begin
      idx  = 4 * int'(a[i]) + 2 * int'(b[i]) + int'(c[i]);
      r[i] = l[idx];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a request in IDLE and returns after the accept edge
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [7:0] l, input string tag);
    int w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    rd = a; rs1 = b; rs2 = c; lut = l; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rd = $urandom; rs1 = $urandom; rs2 = $urandom; lut = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    check({tag, ".latency"}, 32'(lat), 32'(NCHUNK));
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".idle_after_rsp"}, {30'd0, req_ready, rsp_valid}, 32'b10);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [7:0] l, input string tag);
    accept(a, b, c, l, tag);
    wait_done(tag);
    check({tag, ".result"}, result, ref_bop(l, a, b, c));
    release_rsp(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".result"}, result, 32'd0);
  endtask

  localparam logic [31:0] A = 32'hFFFF0000, B = 32'h0F0F0F0F, C = 32'h00FF00FF;

  initial begin
    logic [31:0] a, b, c, hold_res, exp_res;
    logic [7:0]  l;
    int          lat;
    logic [7:0]  luts [6];
    luts[0] = LUT_XOR3; luts[1] = LUT_MAJ; luts[2] = LUT_RD;
    luts[3] = LUT_RS1;  luts[4] = LUT_RS2; luts[5] = 8'h00;

    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; lut = '0;
    flush_w = 1'b0; req_valid_w = 1'b0; rsp_ready_w = 1'b0;
    rd_w = '0; rs1_w = '0; rs2_w = '0; lut_w = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_reset_state("por");

    // Known vectors, including literal expectations
    run_op(A, B, C, LUT_XOR3, "xor3");
    accept(A, B, C, LUT_XOR3, "xor3_lit");
    wait_done("xor3_lit");
    check("xor3_lit.result", result, 32'hF00F0FF0);
    release_rsp("xor3_lit");
    run_op(A, B, C, LUT_RD,  "lut_rd");
    run_op(A, B, C, LUT_RS1, "lut_rs1");
    run_op(A, B, C, LUT_RS2, "lut_rs2");
    run_op(A, B, C, 8'h00,   "lut_00");
    run_op(A, B, C, 8'hFF,   "lut_ff");
    run_op(A, B, C, LUT_MAJ, "lut_maj");

    // Backpressure with req_valid held high in DONE
    accept(A, B, C, LUT_XOR3, "bp");
    wait_done("bp");
    req_valid = 1'b1; rd = '1; rs1 = '1; rs2 = '1; lut = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      check("bp.hold", {29'd0, rsp_valid, req_ready, 1'b0}, 32'b100);
      check("bp.result", result, 32'hF00F0FF0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("bp.release", {30'd0, req_ready, rsp_valid}, 32'b10);
    tick();
    check("bp.no_accept", 32'(req_ready), 32'd1);

    // Flush at cnt==2 with a competing request
    accept(A, B, C, LUT_XOR3, "fl");
    tick(); tick();
    flush = 1'b1; req_valid = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check_reset_state("fl");
    tick();
    check("fl.no_accept", 32'(req_ready), 32'd1);
    run_op(B, C, A, LUT_MAJ, "fl_next");

    // Reset mid-BUSY and in DONE
    accept(A, B, C, LUT_XOR3, "rst_busy");
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_state("rst_busy");
    accept(A, B, C, LUT_XOR3, "rst_done");
    wait_done("rst_done");
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_state("rst_done");

    // Single-chunk build
    for (int k = 0; k < 8; k++) begin
      a = $urandom; b = $urandom; c = $urandom;
      l = (k == 0) ? LUT_MAJ : 8'($urandom);
      rd_w = a; rs1_w = b; rs2_w = c; lut_w = l; req_valid_w = 1'b1;
      tick();
      req_valid_w = 1'b0; rd_w = $urandom; rs1_w = $urandom;
      lat = 0;
      while (!rsp_valid_w && lat < 20) begin tick(); lat++; end
      check("wide.latency", 32'(lat), 32'd1);
      check("wide.result", result_w, ref_bop(l, a, b, c));
      rsp_ready_w = 1'b1; tick(); rsp_ready_w = 1'b0;
      check("wide.idle", 32'(req_ready_w), 32'd1);
    end

    // Random ops with random backpressure and flushes
    for (int k = 0; k < 2000; k++) begin
      a = $urandom; b = $urandom; c = $urandom;
      l = ($urandom_range(0, 1) == 0) ? luts[$urandom_range(0, 5)] : 8'($urandom);
      exp_res = ref_bop(l, a, b, c);
      accept(a, b, c, l, "rnd");
      if ($urandom_range(0, 7) == 0) begin
        for (int j = $urandom_range(0, NCHUNK - 1); j > 0; j--) tick();
        flush = 1'b1; req_valid = $urandom_range(0, 1) == 1;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        check_reset_state("rnd_flush");
      end else begin
        wait_done("rnd");
        check("rnd.result", result, exp_res);
        hold_res = exp_res;
        for (int j = $urandom_range(0, 3); j > 0; j--) begin
          tick();
          check("rnd.hold", {31'd0, rsp_valid}, 32'd1);
        end
        check("rnd.result_held", result, hold_res);
        release_rsp("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
